// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses rPLL RESET, waits for a stable LOCK,
// then releases the core reset; re-sequences on lock loss or timeout.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int CNT_W          = 17
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       LOCK,
  output logic       PLL_RESET,
  output logic       SYS_RESETN,
  output logic [1:0] STATE,
  output logic [3:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT
);

  typedef enum logic [1:0] {
    S_PLLRST   = 2'd0,
    S_WAITLOCK = 2'd1,
    S_STABLE   = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PLL_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             lock_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       retry_q;
  logic [3:0]       retry_d;
  logic [7:0]       loss_q;
  logic [7:0]       loss_d;

  assign lock_s = sync2_q;

  // Two-flop synchronizer bringing async LOCK into CLKIN domain
  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= LOCK;
      sync2_q <= sync1_q;
    end
  end

  // State register with shared cycle counter and event counters
  always_ff @(posedge CLKIN) begin
    if (!RESETN) begin
      state_q <= S_PLLRST;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state and counter update; lock_s beats timeout in WAITLOCK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      S_PLLRST: begin
        if (cnt_q == PLL_LAST) begin
          state_d = S_WAITLOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAITLOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_PLLRST;
          cnt_d   = '0;
          if (retry_q != 4'hf)
            retry_d = retry_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAITLOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_PLLRST;
          cnt_d   = '0;
          if (loss_q != 8'hff)
            loss_d = loss_q + 8'd1;
        end
      end
      default: begin
        state_d = S_PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register
  always_comb begin
    PLL_RESET  = (state_q == S_PLLRST);
    SYS_RESETN = (state_q == S_RUN);
    STATE      = state_q;
    RETRY_CNT  = retry_q;
    LOSS_CNT   = loss_q;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Consumer-side controller for the rPLL: drives the PLL's RESET input and watches its LOCK output.
- Releases a clean active-low system reset to the core only after lock has been continuously stable for a programmed time.
- On loss of lock it re-asserts system reset and re-runs the PLL reset sequence; timeouts trigger retries.
- Runs on the PLL reference clock (not the PLL output), so it keeps operating while the PLL is unlocked.

Parameters:
- PLL_RST_CYCLES, 16, cycles PLL_RESET is held high per PLL reset pulse (>=1).
- STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before system reset release (>=1).
- LOCK_TIMEOUT, 65536, cycles to wait for lock before re-pulsing PLL reset (>=1).
- CNT_W, 17, width of the shared cycle counter; must satisfy 2^CNT_W >= max of the three counts above.

Ports:
- CLKIN  input  1  reference clock (same clock that feeds rPLL CLKIN).
- RESETN  input  1  reset: synchronous, active-low.
- LOCK  input  1  rPLL LOCK; asynchronous to CLKIN.
- PLL_RESET  output  1  to rPLL RESET; active-high.
- SYS_RESETN  output  1  active-low reset to the core clock domain logic.
- STATE  output  2  debug: 0=PLLRST, 1=WAITLOCK, 2=STABLE, 3=RUN.
- RETRY_CNT  output  4  lock-timeout retries, saturating at 15.
- LOSS_CNT  output  8  lock losses while in RUN, saturating at 255.

Behaviour:
- Synchronizer: LOCK passes through two CLKIN flops to give lock_s. The FSM uses only lock_s, never raw LOCK.
- Reset (RESETN sampled low at an edge):
  - state=PLLRST, cnt=0, both sync flops=0.
  - RETRY_CNT=0, LOSS_CNT=0.
  - Outputs during reset: PLL_RESET=1, SYS_RESETN=0, STATE=0.
- Outputs are Moore-decoded directly from the state register, with no extra pipeline stage:
  - PLL_RESET=(state==PLLRST).
  - SYS_RESETN=(state==RUN).
- PLLRST:
  - If cnt==PLL_RST_CYCLES-1: go to WAITLOCK, cnt=0.
  - Else cnt++.
  - lock_s is ignored in this state.
- WAITLOCK:
  - If lock_s: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1: go to PLLRST, cnt=0, RETRY_CNT++ (saturating).
  - Else cnt++.
- STABLE:
  - If !lock_s: go to WAITLOCK, cnt=0. This is a glitch restart; no counters are incremented.
  - Else if cnt==STABLE_CYCLES-1: go to RUN.
  - Else cnt++.
- RUN:
  - If !lock_s: go to PLLRST, cnt=0, LOSS_CNT++ (saturating). SYS_RESETN falls on the same edge.
  - Else hold.
- Precedence:
  - RESETN low overrides every transition.
  - In WAITLOCK, lock_s high on the timeout cycle wins: go to STABLE, no retry counted.
- Saturation: RETRY_CNT stays at 15 and LOSS_CNT stays at 255; they never wrap.
- Reset mid-operation (any state): returns to the reset values on the next edge. Counters are cleared; this is the only way to clear them.
- Latency with LOCK high from power-up (edge n = n-th edge with RESETN high):
  - PLL_RESET low after edge PLL_RST_CYCLES.
  - SYS_RESETN high after edge PLL_RST_CYCLES+1+STABLE_CYCLES.
- Latency of lock loss: SYS_RESETN deasserts 3 edges after LOCK falls (2 sync + 1 FSM).

Test Plan (PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, CNT_W=6):
1. Clean start, LOCK=1 throughout.
   - PLL_RESET=1 through edge 3 and 0 after edge 4.
   - STATE=2 after edge 5.
   - SYS_RESETN=1 after edge 13, STATE=3.
   - RETRY_CNT=0, LOSS_CNT=0.
2. LOCK=0 forever.
   - WAITLOCK after edge 4; PLLRST after edge 36 with RETRY_CNT=1.
   - Repeats every 36 edges.
   - After 20 timeouts, RETRY_CNT=15 (saturated).
3. Lock glitch during STABLE: LOCK drops for 1 cycle after 5 stable cycles.
   - Returns to WAITLOCK, then re-enters STABLE.
   - SYS_RESETN rises only after 8 fresh consecutive cycles.
   - RETRY_CNT and LOSS_CNT unchanged.
4. Lock loss in RUN: LOCK falls at edge k.
   - SYS_RESETN=0 and PLL_RESET=1 after edge k+3; LOSS_CNT=1.
   - With LOCK restored, SYS_RESETN=1 again 4+1+8 edges later.
5. Reset mid-STABLE: RESETN low for 1 edge.
   - STATE=0, PLL_RESET=1, SYS_RESETN=0, counters 0.
   - Sequence restarts from edge 0 timing as in scenario 1.
6. Timeout tie: lock_s first high on the edge where WAITLOCK cnt==31.
   - Goes to STABLE, RETRY_CNT unchanged.
7. 260 RUN lock-loss events: LOSS_CNT=255.
